// File: rtl/imem_loader.sv
// Boot loader: buffers a host-supplied program in a FIFO, then streams it into the
// CPU instruction memory while sequencing the CPU reset around the transfer.
`timescale 1ns/1ps
module imem_loader #(
    parameter int DEPTH    = 32,
    parameter int POST_RST = 2
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     host_valid,
    input  logic [31:0]              host_data,
    input  logic                     host_last,
    output logic                     host_ready,
    input  logic                     restart,
    output logic                     LoadInstructions,
    output logic [31:0]              Instruction,
    output logic                     cpu_reset,
    output logic [$clog2(DEPTH):0]   load_count,
    output logic                     done
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = (POST_RST > 1) ? $clog2(POST_RST + 1) : 1;

    localparam logic [2:0] S_FILL    = 3'd0;
    localparam logic [2:0] S_PRERST  = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_POSTRST = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;

    logic [31:0]   mem [DEPTH];
    logic [2:0]    state, state_d;
    logic [AW-1:0] wptr, wptr_d, rptr, rptr_d;
    logic [CW-1:0] count, count_d, lc_d;
    logic [PW-1:0] post_cnt, post_d;
    logic          push, pop, accept;
    logic          ready_d, cpu_reset_d, load_d, done_d;
    logic [31:0]   instr_d;

    assign accept = (state == S_FILL) && host_valid && host_ready;

    // Next state plus the next value of every registered output
    always_comb begin
        state_d = state;
        post_d  = post_cnt;
        push    = 1'b0;
        pop     = 1'b0;
        case (state)
            S_FILL: begin
                if (accept) begin
                    push = 1'b1;
                    if (host_last || (count == CW'(DEPTH - 1))) state_d = S_PRERST;
                end
            end
            S_PRERST: begin
                state_d = S_STREAM;
                pop     = 1'b1;
            end
            S_STREAM: begin
                // count already reflects the word on Instruction; empty means last word shown
                if (count != '0) begin
                    pop = 1'b1;
                end else begin
                    state_d = S_POSTRST;
                    post_d  = '0;
                end
            end
            S_POSTRST: begin
                if (post_cnt == PW'(POST_RST - 1)) state_d = S_RUN;
                else                               post_d  = post_cnt + PW'(1);
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_FILL;
        endcase

        if (restart) begin
            state_d = S_FILL;
            push    = 1'b0;
            pop     = 1'b0;
        end

        wptr_d  = push ? ((wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1)) : wptr;
        rptr_d  = pop  ? ((rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1)) : rptr;
        count_d = count + CW'(push) - CW'(pop);
        lc_d    = load_count + CW'(push);
        if (restart) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            lc_d    = '0;
        end

        ready_d     = (state_d == S_FILL) && (count_d != CW'(DEPTH));
        cpu_reset_d = (state_d == S_FILL) || (state_d == S_PRERST) || (state_d == S_POSTRST);
        load_d      = (state_d == S_STREAM);
        done_d      = (state_d == S_RUN);
        instr_d     = pop ? mem[rptr] : 32'd0;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state            <= S_FILL;
            wptr             <= '0;
            rptr             <= '0;
            count            <= '0;
            post_cnt         <= '0;
            load_count       <= '0;
            host_ready       <= 1'b0;
            cpu_reset        <= 1'b1;
            LoadInstructions <= 1'b0;
            Instruction      <= 32'd0;
            done             <= 1'b0;
        end else begin
            state            <= state_d;
            wptr             <= wptr_d;
            rptr             <= rptr_d;
            count            <= count_d;
            post_cnt         <= post_d;
            load_count       <= lc_d;
            host_ready       <= ready_d;
            cpu_reset        <= cpu_reset_d;
            LoadInstructions <= load_d;
            Instruction      <= instr_d;
            done             <= done_d;
        end
    end

    // Storage needs no reset; pointers and occupancy define validity
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= host_data;
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of program loads plus hand-written
// restart / reset corner cases; streamed words are checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_imem_loader;
    localparam int DEPTH    = 32;
    localparam int POST_RST = 2;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        host_valid = 1'b0;
    logic [31:0] host_data = 32'd0;
    logic        host_last = 1'b0;
    logic        restart = 1'b0;
    logic        host_ready, LoadInstructions, cpu_reset, done;
    logic [31:0] Instruction;
    logic [$clog2(DEPTH):0] load_count;

    imem_loader #(.DEPTH(DEPTH), .POST_RST(POST_RST)) dut (
        .clk(clk), .Reset(Reset), .host_valid(host_valid), .host_data(host_data),
        .host_last(host_last), .host_ready(host_ready), .restart(restart),
        .LoadInstructions(LoadInstructions), .Instruction(Instruction),
        .cpu_reset(cpu_reset), .load_count(load_count), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        int          gap;
        bit          use_last;
        bit          poke;
        bit          spec;
        logic [31:0] base;
        int          exp_count;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] spec_words[3];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every streamed word must be the next one pushed by the driver
    always @(negedge clk) begin
        if (Reset) begin
            if (LoadInstructions) begin
                if (exp_q.size() == 0) check("stream_unexpected_word", Instruction, 32'hxxxx_xxxx);
                else                   check("stream_word", Instruction, exp_q.pop_front());
            end else if (Instruction !== 32'd0) begin
                check("instr_zero_when_idle", Instruction, 32'd0);
            end
        end
    end

    function automatic logic [31:0] word_of(input vec_t v, input int i);
        if (v.spec) return spec_words[i];
        return v.base + 32'(i) * 32'h0001_0001;
    endfunction

    // Offers v.n words; during gap cycles host_last is raised with host_valid low
    task automatic load_program(input vec_t v);
        for (int i = 0; i < v.n; i++) begin
            int t = 0;
            while (!host_ready && t < 50) begin
                @(negedge clk);
                t++;
            end
            if (!host_ready) begin
                check("ready_timeout", 32'(host_ready), 32'd1);
                return;
            end
            host_valid = 1'b1;
            host_data  = word_of(v, i);
            host_last  = v.use_last && (i == v.n - 1);
            exp_q.push_back(host_data);
            @(negedge clk);
            host_valid = 1'b0;
            host_last  = 1'b0;
            if (i != v.n - 1) begin
                for (int g = 0; g < v.gap; g++) begin
                    host_last = 1'b1;
                    @(negedge clk);
                end
                host_last = 1'b0;
            end
        end
        check("ready_low_after_load", 32'(host_ready), 32'd0);
    endtask

    // Measures PRERST / STREAM / POSTRST lengths until done, then checks RUN outputs
    task automatic run_to_done(input vec_t v);
        int p = 0, s = 0, q = 0;
        if (v.poke) begin
            host_valid = 1'b1;
            host_last  = 1'b1;
            host_data  = 32'hDEAD_BEEF;
        end
        for (int t = 0; t < 400 && !done; t++) begin
            if (LoadInstructions) s++;
            else if (cpu_reset) begin
                if (s == 0) p++;
                else        q++;
            end
            @(negedge clk);
            host_valid = 1'b0;
            host_last  = 1'b0;
        end
        check("done", 32'(done), 32'd1);
        check("prerst_cycles", 32'(p), 32'd1);
        check("stream_cycles", 32'(s), 32'(v.exp_count));
        check("postrst_cycles", 32'(q), 32'(POST_RST));
        check("load_count", 32'(load_count), 32'(v.exp_count));
        check("run_cpu_reset", 32'(cpu_reset), 32'd0);
        check("run_host_ready", 32'(host_ready), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_load", 32'(LoadInstructions), 32'd0);
        check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        check("restart_load_count", 32'(load_count), 32'd0);
        check("restart_host_ready", 32'(host_ready), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_load(input logic level);
        int t = 0;
        while (LoadInstructions !== level && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("wait_load_level", 32'(LoadInstructions), 32'(level));
    endtask

    initial begin
        vec_t h;
        spec_words[0] = 32'h2001_0005;
        spec_words[1] = 32'h2002_0003;
        spec_words[2] = 32'h0022_1820;
        vecs[0] = '{n: 3,     gap: 0, use_last: 1'b1, poke: 1'b0, spec: 1'b1, base: 32'h0,         exp_count: 3};
        vecs[1] = '{n: DEPTH, gap: 0, use_last: 1'b0, poke: 1'b1, spec: 1'b0, base: 32'h1000_0000, exp_count: DEPTH};
        vecs[2] = '{n: 4,     gap: 1, use_last: 1'b1, poke: 1'b0, spec: 1'b0, base: 32'hA5A5_0000, exp_count: 4};
        vecs[3] = '{n: 1,     gap: 0, use_last: 1'b1, poke: 1'b0, spec: 1'b0, base: 32'h0BAD_F00D, exp_count: 1};
        vecs[4] = '{n: 6,     gap: 2, use_last: 1'b1, poke: 1'b0, spec: 1'b0, base: 32'h7000_0007, exp_count: 6};

        repeat (3) @(negedge clk);
        check("rst_host_ready", 32'(host_ready), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_load", 32'(LoadInstructions), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_instruction", Instruction, 32'd0);
        Reset = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(host_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            load_program(vecs[i]);
            run_to_done(vecs[i]);
            do_restart();
        end

        // Restart during the second STREAM cycle
        h = '{n: 4, gap: 0, use_last: 1'b1, poke: 1'b0, spec: 1'b0, base: 32'h5555_0000, exp_count: 4};
        load_program(h);
        wait_load(1'b1);
        @(negedge clk);
        do_restart();

        // Reset asserted mid-STREAM drops the load enable without a clock edge
        h.n = 3;
        h.exp_count = 3;
        load_program(h);
        wait_load(1'b1);
        #1 Reset = 1'b0;
        #1;
        check("async_rst_load", 32'(LoadInstructions), 32'd0);
        check("async_rst_instruction", Instruction, 32'd0);
        check("async_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        @(negedge clk);
        Reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("ready_after_rst_stream", 32'(host_ready), 32'd1);

        // Reset asserted mid-POSTRST, then a fresh 1-word load
        h.n = 2;
        h.exp_count = 2;
        load_program(h);
        wait_load(1'b1);
        wait_load(1'b0);
        check("in_postrst_cpu_reset", 32'(cpu_reset), 32'd1);
        #1 Reset = 1'b0;
        #1;
        check("postrst_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("postrst_rst_done", 32'(done), 32'd0);
        check("postrst_rst_load_count", 32'(load_count), 32'd0);
        check("postrst_rst_host_ready", 32'(host_ready), 32'd0);
        @(negedge clk);
        Reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("ready_after_rst_postrst", 32'(host_ready), 32'd1);
        h = '{n: 1, gap: 0, use_last: 1'b1, poke: 1'b0, spec: 1'b0, base: 32'hC0DE_0001, exp_count: 1};
        load_program(h);
        run_to_done(h);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL take parameter DEPTH, default 32, meaning the program buffer size in 32-bit words.
REQ-002 SHALL take parameter POST_RST, default 2, meaning the number of cycles cpu_reset is held after streaming.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-005 SHALL have port host_valid, input, 1 bit, meaning the host offers a word.
REQ-006 SHALL have port host_data, input, 32 bits, the instruction word offered.
REQ-007 SHALL have port host_last, input, 1 bit, marking the offered word as the final program word.
REQ-008 SHALL have port host_ready, output, 1 bit, meaning the loader accepts a word this cycle.
REQ-009 SHALL have port restart, input, 1 bit, a synchronous request to reload.
REQ-010 SHALL have port LoadInstructions, output, 1 bit, the CPU instruction-memory load enable.
REQ-011 SHALL have port Instruction, output, 32 bits, the CPU instruction-memory write data.
REQ-012 SHALL have port cpu_reset, output, 1 bit, an active-high reset driven to the CPU Reset input.
REQ-013 SHALL have port load_count, output, clog2(DEPTH)+1 bits, the number of words captured.
REQ-014 SHALL have port done, output, 1 bit, meaning the CPU is running the loaded program.

Function
REQ-015 SHALL implement the states FILL, PRERST, STREAM, POSTRST and RUN.
REQ-016 SHALL contain a DEPTH-word FIFO with wrap-around read and write pointers and an occupancy counter.
REQ-017 SHALL, in FILL, drive host_ready = !full and cpu_reset=1, and write host_data on (host_valid && host_ready).
REQ-018 SHALL move from FILL to PRERST on the edge that accepts a word with host_last=1, or on the edge the FIFO reaches DEPTH words.
REQ-019 SHALL, in FILL, ignore host_last when host_valid=0 or host_ready=0; host_last never produces an empty program.
REQ-020 SHALL set load_count to the number of accepted words and hold it until the next entry into FILL.
REQ-021 SHALL keep PRERST for exactly 1 cycle with cpu_reset=1 and LoadInstructions=0.
REQ-022 SHALL, in STREAM, drive cpu_reset=0 and LoadInstructions=1, and set Instruction to the FIFO head word.
REQ-023 SHALL pop one FIFO word per STREAM cycle with no bubbles, so that word k appears in STREAM cycle k (k from 0), aligned to a CPU address counter released at STREAM entry.
REQ-024 SHALL leave STREAM for POSTRST after exactly load_count cycles.
REQ-025 SHALL drive Instruction=0 whenever LoadInstructions=0.
REQ-026 SHALL, in POSTRST, hold cpu_reset=1 and LoadInstructions=0 for POST_RST cycles, then enter RUN.
REQ-027 SHALL, in RUN, drive cpu_reset=0, done=1 and host_ready=0; RUN persists until restart or Reset.
REQ-028 SHALL drive host_ready=0 and done=0 in every state other than FILL and RUN respectively.
REQ-029 SHALL, when restart=1 in any state, enter FILL on the next edge, clear the FIFO and load_count, and drive cpu_reset=1 and LoadInstructions=0 from that edge.
REQ-030 SHALL give restart priority over every other transition when both occur in the same cycle.
REQ-031 SHALL drive cpu_reset, LoadInstructions, done and host_ready from registered state only, with no combinational path from inputs except host_ready's dependence on full.

Reset
REQ-032 SHALL, while Reset=0, asynchronously force state FILL, empty the FIFO, and drive load_count=0, cpu_reset=1, LoadInstructions=0, Instruction=0, done=0 and host_ready=0.
REQ-033 SHALL, on Reset release, raise host_ready=1 at the first clk edge.
REQ-034 SHALL, when Reset is asserted mid-STREAM, drop LoadInstructions within the same cycle, without waiting for a clock edge.

Verification
REQ-035 SHALL cover a 3-word load: words 0x20010005, 0x20020003, 0x00221820 with last on the third -> PRERST for 1 cycle, STREAM for 3 cycles presenting the words in order, cpu_reset high for 2 cycles, then done=1 and load_count=3.
REQ-036 SHALL cover a 32 back-to-back words with host_last=0 -> host_ready falls after word 32, STREAM lasts 32 cycles, and load_count=32.
REQ-037 SHALL cover host_valid toggling every other cycle for 4 words -> exactly 4 words captured, and STREAM still streams them with no bubbles.
REQ-038 SHALL cover restart=1 in the 2nd STREAM cycle -> next cycle FILL, LoadInstructions=0, cpu_reset=1, load_count=0 and host_ready=1.
REQ-039 SHALL cover Reset=0 mid-POSTRST -> immediate cpu_reset=1 and done=0; after release, a fresh 1-word load completes with load_count=1.
REQ-040 SHALL cover host_valid=1 with host_last=1 in the cycle the FIFO is full -> the word is not accepted and load_count=DEPTH.
